alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Operand front-end and result register for the Mini ALU. Loads A, B and the function code over one shared 6-bit load port with a valid/ready handshake, then holds them stable on the ALU operand lines. After one settle cycle it captures the ALU result selector's `final` and `final_of` into registers and offers them downstream with a valid/ready handshake. It also keeps a sticky overflow flag and an operation counter.

## Interface
- WIDTH, 6, operand/result width (matches ALU datapath)
- CNT_W, 8, width of completed-operation counter

- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- load_data  input  WIDTH  shared operand bus (A word, then B word)
- load_func  input  3  function code, sampled together with the B word
- load_valid  input  1  load_data/load_func valid
- load_ready  output  1  sequencer accepts a word this cycle
- alu_a  output  WIDTH  registered operand A to ALU
- alu_b  output  WIDTH  registered operand B to ALU
- alu_func  output  3  registered function code to ALU/result selector
- alu_final  input  WIDTH  result from result selector
- alu_final_of  input  1  overflow from result selector
- result  output  WIDTH  captured result
- result_of  output  1  captured overflow
- result_valid  output  1  result/result_of valid
- result_ready  input  1  downstream accepts result
- sticky_of  output  1  set by any captured overflow, held until cleared
- clear_sticky  input  1  synchronous clear of sticky_of
- op_count  output  CNT_W  completed (consumed) operations, wraps

## Operation
- FSM states: LOAD_A, LOAD_B, EXEC, HOLD; reset state LOAD_A.
- load_ready = 1 in LOAD_A and LOAD_B, 0 in EXEC/HOLD; forced 0 while reset is high.
- LOAD_A: on load_valid, alu_a <= load_data, then go to LOAD_B. Otherwise stay.
- LOAD_B: on load_valid, alu_b <= load_data, alu_func <= load_func, then go to EXEC. load_func is ignored in LOAD_A.
- EXEC: exactly one cycle. result <= alu_final, result_of <= alu_final_of, result_valid <= 1. If alu_final_of, sticky_of <= 1. Go to HOLD.
- HOLD: result_valid = 1 with result stable. When result_ready = 1: result_valid <= 0, op_count <= op_count + 1 (mod 2^CNT_W), go to LOAD_A.
- alu_a, alu_b and alu_func change only on accepted loads. They are held through EXEC and HOLD.
- clear_sticky clears sticky_of in any state. If the capture of an overflow falls in the same cycle as clear_sticky, set wins (sticky_of = 1).
- No arithmetic in this block except op_count. result is a raw copy of alu_final, with no sign handling.

## Timing
- Reset values: alu_a = 0, alu_b = 0, alu_func = 3'b000, result = 0, result_of = 0, result_valid = 0, sticky_of = 0, op_count = 0, load_ready = 0 while reset is asserted and 1 after release.
- Reset applies immediately (asynchronous) in any state, including mid-load or while HOLD has an unconsumed result. The unconsumed result is discarded and op_count is not incremented.
- Latency: B accepted at edge N, then result_valid = 1 after edge N+1.
- Minimum op period is 4 cycles (A, B, EXEC, HOLD with result_ready = 1). A new A load is accepted in the cycle after the HOLD handshake.
- result_ready while not in HOLD has no effect.
- load_valid while load_ready = 0 is ignored. The word is not queued.
- Gaps in load_valid between A and B are allowed. The FSM waits in LOAD_B indefinitely.

## Test plan
- A = 6'd5, B = 6'd3, func = 3'b110, result_ready = 1 -> result = 6'd8, result_of = 0, result_valid high for 1 cycle, op_count = 1.
- A = 6'd31, B = 6'd1, func = 3'b110 -> result = 6'b100000, result_of = 1, sticky_of = 1. It stays 1 across a following non-overflow op and clears 1 cycle after clear_sticky.
- Backpressure: result_ready = 0 for 5 cycles after a valid result -> result and result_valid stable, load_ready = 0, load_valid pulses ignored, alu_a/alu_b unchanged. Raising result_ready -> handshake, then LOAD_A.
- Reset mid-op: A = 6'd9 accepted, then reset pulsed in LOAD_B -> alu_a = 0 immediately, state LOAD_A, result_valid = 0, op_count unchanged at 0.
- Load gaps: A accepted, load_valid low 3 cycles, then B = 6'd2 with func = 3'b111 -> alu_func = 3'b111 and the result appears 1 edge after B is accepted.
- 256 back-to-back ops with CNT_W = 8 -> op_count wraps to 0. Clear_sticky coinciding with an overflow capture -> sticky_of = 1.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Operand front-end and result register for the Mini ALU: loads A, then B plus
// function code over one load port, holds them for the ALU, captures the result.
module alu_op_sequencer #(
  parameter int WIDTH = 6,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_data,
  input  logic [2:0]       load_func,
  input  logic             load_valid,
  output logic             load_ready,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_func,
  input  logic [WIDTH-1:0] alu_final,
  input  logic             alu_final_of,
  output logic [WIDTH-1:0] result,
  output logic             result_of,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             sticky_of,
  input  logic             clear_sticky,
  output logic [CNT_W-1:0] op_count,
  output logic [1:0]       state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; the sender holds its data until then, and valid without ready is dropped.
  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    EXEC   = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [2:0]       alu_func_q, alu_func_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             result_of_q, result_of_d;
  logic             result_valid_q, result_valid_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  logic load_a_en, load_b_en, capture_en, done_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= LOAD_A;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_func_q     <= 3'b000;
      result_q       <= '0;
      result_of_q    <= 1'b0;
      result_valid_q <= 1'b0;
      sticky_q       <= 1'b0;
      op_count_q     <= '0;
    end else begin
      state_q        <= state_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      alu_func_q     <= alu_func_d;
      result_q       <= result_d;
      result_of_q    <= result_of_d;
      result_valid_q <= result_valid_d;
      sticky_q       <= sticky_d;
      op_count_q     <= op_count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD_A:  if (load_valid) state_d = LOAD_B;
      LOAD_B:  if (load_valid) state_d = EXEC;
      EXEC:    state_d = HOLD;
      HOLD:    if (result_ready) state_d = LOAD_A;
      default: state_d = LOAD_A;
    endcase
  end

  always_comb begin
    load_ready = ((state_q == LOAD_A) || (state_q == LOAD_B)) && !reset;
    load_a_en  = (state_q == LOAD_A) && load_valid;
    load_b_en  = (state_q == LOAD_B) && load_valid;
    capture_en = (state_q == EXEC);
    done_en    = (state_q == HOLD) && result_ready;
    state_dbg  = state_q;
  end

  always_comb begin
    alu_a_d        = load_a_en ? load_data : alu_a_q;
    alu_b_d        = load_b_en ? load_data : alu_b_q;
    alu_func_d     = load_b_en ? load_func : alu_func_q;
    result_d       = capture_en ? alu_final : result_q;
    result_of_d    = capture_en ? alu_final_of : result_of_q;
    result_valid_d = result_valid_q;
    if (capture_en)   result_valid_d = 1'b1;
    else if (done_en) result_valid_d = 1'b0;
    // A captured overflow outranks a simultaneous clear.
    sticky_d = sticky_q;
    if (capture_en && alu_final_of) sticky_d = 1'b1;
    else if (clear_sticky)          sticky_d = 1'b0;
    op_count_d = done_en ? op_count_q + 1'b1 : op_count_q;
  end

  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_func     = alu_func_q;
  assign result       = result_q;
  assign result_of    = result_of_q;
  assign result_valid = result_valid_q;
  assign sticky_of    = sticky_q;
  assign op_count     = op_count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a behavioural ALU sits on the operand lines, a driver
// issues operations and a monitor scores every presented result against a queue.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] load_data = '0;
  logic [2:0] load_func = '0;
  logic       load_valid = 1'b0;
  logic       load_ready;
  logic [5:0] alu_a, alu_b;
  logic [2:0] alu_func;
  logic [5:0] alu_final;
  logic       alu_final_of;
  logic [5:0] result;
  logic       result_of, result_valid;
  logic       result_ready = 1'b0;
  logic       sticky_of;
  logic       clear_sticky = 1'b0;
  logic [7:0] op_count;
  logic [1:0] state_dbg;

  int checks = 0;
  int failures = 0;

  // {func, a, b, of, result}
  logic [21:0] exp_q[$];
  logic [21:0] mon_e;
  logic [7:0]  exp_count = '0;
  logic        exp_sticky = 1'b0;
  logic        cap_now = 1'b0;
  logic        cap_of = 1'b0;

  alu_op_sequencer #(.WIDTH(6), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .load_data(load_data), .load_func(load_func), .load_valid(load_valid),
    .load_ready(load_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
    .alu_final(alu_final), .alu_final_of(alu_final_of),
    .result(result), .result_of(result_of), .result_valid(result_valid),
    .result_ready(result_ready),
    .sticky_of(sticky_of), .clear_sticky(clear_sticky),
    .op_count(op_count), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Mini ALU behaviour: signed add/sub flag overflow outside -32..31.
  function automatic logic [6:0] alu_model(input logic [5:0] a, input logic [5:0] b,
                                           input logic [2:0] f);
    int sa, sb, s;
    logic [5:0] r;
    logic of;
    sa = $signed(a);
    sb = $signed(b);
    s = 0;
    of = 1'b0;
    case (f)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = a ^ b;
      3'd3: r = ~a;
      3'd4: r = a;
      3'd5: r = b;
      3'd6: s = sa + sb;
      default: s = sa - sb;
    endcase
    if (f >= 3'd6) begin
      r = 6'(s);
      of = (s > 31) || (s < -32);
    end
    return {of, r};
  endfunction

  always_comb {alu_final_of, alu_final} = alu_model(alu_a, alu_b, alu_func);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // sticky model: capture overflow sets, clear clears, set wins
  always @(posedge clk or posedge reset) begin
    if (reset) exp_sticky = 1'b0;
    else if (cap_now && cap_of) exp_sticky = 1'b1;
    else if (clear_sticky) exp_sticky = 1'b0;
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (!reset) begin
      chk("op_count", 32'(op_count), 32'(exp_count));
      chk("sticky_of", 32'(sticky_of), 32'(exp_sticky));
      if (result_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'(1), 32'(0));
        end else begin
          mon_e = exp_q[0];
          chk("result", 32'(result), 32'(mon_e[5:0]));
          chk("result_of", 32'(result_of), 32'(mon_e[6]));
          chk("alu_b_held", 32'(alu_b), 32'(mon_e[12:7]));
          chk("alu_a_held", 32'(alu_a), 32'(mon_e[18:13]));
          chk("alu_func_held", 32'(alu_func), 32'(mon_e[21:19]));
          if (result_ready) begin
            void'(exp_q.pop_front());
            exp_count = exp_count + 8'd1;
          end
        end
      end
    end
  end

  // driver: one full operation, entered just after an edge with the DUT idle in LOAD_A
  task automatic do_op(input logic [5:0] a, input logic [5:0] b, input logic [2:0] f,
                       input int gap, input int rdly, input bit clr_exec);
    logic [6:0] m;
    load_valid = 1'b1;
    load_data  = a;
    load_func  = 3'($urandom);
    @(negedge clk);
    chk("ready_a", 32'(load_ready), 32'(1));
    @(posedge clk); #1;
    load_valid = 1'b0;
    load_data  = 6'($urandom);
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      chk("gap_ready", 32'(load_ready), 32'(1));
      chk("gap_rv", 32'(result_valid), 32'(0));
      @(posedge clk); #1;
    end
    load_valid = 1'b1;
    load_data  = b;
    load_func  = f;
    @(negedge clk);
    chk("ready_b", 32'(load_ready), 32'(1));
    @(posedge clk);
    m = alu_model(a, b, f);
    exp_q.push_back({f, a, b, m});
    #1;
    cap_now      = 1'b1;
    cap_of       = m[6];
    clear_sticky = clr_exec;
    load_valid   = 1'($urandom);
    load_data    = 6'($urandom);
    load_func    = 3'($urandom);
    result_ready = (rdly == 0) ? 1'b1 : 1'($urandom);
    @(negedge clk);
    chk("exec_rv", 32'(result_valid), 32'(0));
    chk("exec_ready", 32'(load_ready), 32'(0));
    chk("exec_func", 32'(alu_func), 32'(f));
    @(posedge clk); #1;
    cap_now      = 1'b0;
    clear_sticky = 1'b0;
    for (int i = 0; i < rdly; i++) begin
      result_ready = 1'b0;
      load_valid   = 1'($urandom);
      load_data    = 6'($urandom);
      @(negedge clk);
      chk("bp_rv", 32'(result_valid), 32'(1));
      chk("bp_ready", 32'(load_ready), 32'(0));
      @(posedge clk); #1;
    end
    result_ready = 1'b1;
    load_valid   = 1'b0;
    @(negedge clk);
    chk("hold_rv", 32'(result_valid), 32'(1));
    @(posedge clk); #1;
    result_ready = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_sticky = 1'b1;
    @(posedge clk); #1;
    clear_sticky = 1'b0;
  endtask

  initial begin
    #3 reset = 1'b1;
    @(negedge clk);
    chk("rst_alu_a", 32'(alu_a), 32'(0));
    chk("rst_alu_b", 32'(alu_b), 32'(0));
    chk("rst_alu_func", 32'(alu_func), 32'(0));
    chk("rst_result", 32'(result), 32'(0));
    chk("rst_result_of", 32'(result_of), 32'(0));
    chk("rst_rv", 32'(result_valid), 32'(0));
    chk("rst_sticky", 32'(sticky_of), 32'(0));
    chk("rst_op_count", 32'(op_count), 32'(0));
    chk("rst_load_ready", 32'(load_ready), 32'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(load_ready), 32'(1));
    @(posedge clk); #1;

    // reset while waiting for B
    load_valid = 1'b1;
    load_data  = 6'd9;
    @(posedge clk); #1;
    load_valid = 1'b0;
    @(negedge clk);
    chk("mid_alu_a", 32'(alu_a), 32'(9));
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_alu_a", 32'(alu_a), 32'(0));
    chk("mid_rst_ready", 32'(load_ready), 32'(0));
    chk("mid_rst_rv", 32'(result_valid), 32'(0));
    chk("mid_rst_count", 32'(op_count), 32'(0));
    chk("mid_rst_state", 32'(state_dbg), 32'(0));
    @(posedge clk); #1;
    reset = 1'b0;

    do_op(6'd5, 6'd3, 3'b110, 0, 0, 1'b0);
    do_op(6'd31, 6'd1, 3'b110, 0, 0, 1'b0);
    do_op(6'd2, 6'd2, 3'b110, 0, 0, 1'b0);
    pulse_clear();
    do_op(6'd7, 6'd9, 3'b000, 0, 5, 1'b0);
    do_op(6'd20, 6'd2, 3'b111, 3, 0, 1'b0);
    do_op(6'd31, 6'd1, 3'b110, 0, 0, 1'b1);
    pulse_clear();

    for (int n = 0; n < 40; n++) begin
      do_op(6'($urandom), 6'($urandom), 3'($urandom), $urandom_range(0, 3),
            $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) pulse_clear();
    end

    for (int n = 0; n < 256; n++)
      do_op(6'($urandom), 6'($urandom), 3'($urandom), 0, 0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
